mux_nx1_rr: RTL
===============

MUX_NX1_RR -- requirements
Module: mux_nx1_rr

Interface
REQ-001 SHALL have parameter N, default 4: number of input channels, legal range 2..16.
REQ-002 SHALL have parameter W, default 32: data width per channel, in bits.
REQ-003 SHALL have derived constant SW = clog2(N), the select and channel-index width.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port mode, input, 1: 0 = fixed select, 1 = round-robin.
REQ-007 SHALL have port sel, input, SW: the channel chosen in fixed-select mode.
REQ-008 SHALL have port in_data, input, N*W: channel i occupies bits [i*W +: W].
REQ-009 SHALL have port in_valid, input, N: per-channel valid.
REQ-010 SHALL have port in_ready, output, N: per-channel ready.
REQ-011 SHALL have port out_data, output, W: the registered output data.
REQ-012 SHALL have port out_chan, output, SW: the source channel of out_data.
REQ-013 SHALL have port out_valid, output, 1: out_data is valid.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts the output.

Function
REQ-015 SHALL take a channel i transfer when in_valid[i] and in_ready[i] are both high at the clock edge.
REQ-016 SHALL take an output transfer when out_valid and out_ready are both high at the clock edge.
REQ-017 SHALL define load_en = !out_valid || out_ready, so a full output register accepts new data in the same cycle it drains.
REQ-018 SHALL, in mode 0, grant channel sel only when sel < N and in_valid[sel] is high; otherwise no channel is granted.
REQ-019 SHALL, in mode 1, grant the first valid channel searching ptr+1, ptr+2, ... modulo N, ending with ptr itself.
REQ-020 SHALL keep in_ready one-hot or zero: in_ready[g] = load_en for the granted channel g, 0 for all others; it is combinational from in_valid, mode, sel, ptr, out_valid and out_ready.
REQ-021 SHALL, on a channel transfer, load out_data with the granted channel's data, load out_chan with g, and set out_valid to 1 on the next edge (one-cycle latency).
REQ-022 SHALL, on an output transfer with no new grant, clear out_valid; out_data and out_chan then hold their last values.
REQ-023 SHALL hold out_data and out_chan stable while out_valid is high and out_ready is low.
REQ-024 SHALL update ptr to g only on a channel transfer, in either mode, so that after mode 0 traffic, round-robin resumes after the last served channel.
REQ-025 SHALL make changes to mode or sel take effect in the same cycle's grant and never disturb the output register contents.
REQ-026 SHALL sustain back-to-back throughput of one transfer per cycle while out_ready stays high.
REQ-027 SHALL be starvation-free in mode 1: a continuously valid channel is served within N transfers.

Reset
REQ-028 SHALL, while rst_n is low, force out_valid=0, out_data=0, out_chan=0 and ptr=N-1, so channel 0 has first priority; this holds regardless of clk.
REQ-029 SHALL discard the contents of the output register on reset mid-operation; no transfer is reported for that cycle.
REQ-030 SHALL drive in_ready to all-zero while rst_n is low.

Structure
REQ-031 SHALL place the mode encodings (MODE_FIXED=0, MODE_RR=1) in a shared package, mux_pkg.
REQ-032 SHALL implement the rotating priority search as the combinational sub-module rr_arbiter, with parameter N, inputs req[N] and ptr[SW], and outputs gnt_valid and gnt_idx[SW].
REQ-033 SHALL keep the output register and ptr register in mux_nx1_rr itself.

Verification
REQ-034 SHALL cover fixed select (mode=0, sel=2, in_valid=4'b1111, in_data ch2=32'hC0DE_0002, out_ready=1) -> in_ready=4'b0100; one cycle later out_data=32'hC0DE_0002, out_chan=2, out_valid=1.
REQ-035 SHALL cover round-robin after reset (mode=1, in_valid=4'b1111, out_ready=1 for 5 cycles) -> out_chan sequence 0,1,2,3,0.
REQ-036 SHALL cover backpressure (out_valid=1, out_ready=0, in_valid=4'b0010) -> in_ready=0; out_data is unchanged for 3 cycles; after out_ready rises, ch1 is loaded on the next edge.
REQ-037 SHALL cover an invalid or idle select (mode=0, sel=1, in_valid=4'b1101) -> in_ready=0 and out_valid falls after the pending output drains.
REQ-038 SHALL cover a mode switch (mode 0 serves ch3, then mode=1 with in_valid=4'b1001) -> the next out_chan is 0, then 3.
REQ-039 SHALL cover reset mid-transfer (assert rst_n=0 asynchronously while out_valid=1) -> out_valid=0, out_data=0, out_chan=0 immediately; the first grant after release goes to ch0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 registered multiplexer.
package mux_pkg;

  // Selection policy driven on the mode port.
  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  localparam int unsigned N_MIN = 2;
  localparam int unsigned N_MAX = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority search: first requester after ptr, wrapping, ptr itself last.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          gnt_valid,
  output logic [SW-1:0] gnt_idx
);

  // Scan ptr+1 .. ptr+N modulo N and keep the first hit.
  always_comb begin
    int unsigned idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SW'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_nx1_rr.sv
// N:1 multiplexer with fixed or round-robin channel selection and a
// one-deep registered output stage with valid/ready handshakes.
module mux_nx1_rr
  import mux_pkg::*;
#(
  parameter  int unsigned N  = 4,
  parameter  int unsigned W  = 32,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [SW-1:0] ptr;
  logic          rr_valid;
  logic [SW-1:0] rr_idx;
  logic          gnt_valid;
  logic [SW-1:0] gnt_idx;
  logic          load_en;
  logic          take;

  rr_arbiter #(.N(N)) u_rr_arbiter (
    .req       (in_valid),
    .ptr       (ptr),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  // Output register can accept when empty or draining this cycle.
  assign load_en = !out_valid || out_ready;

  // Grant selection; out-of-range sel grants nothing.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (mode_e'(mode) == MODE_RR) begin
      gnt_valid = rr_valid;
      gnt_idx   = rr_idx;
    end else if (32'(sel) < N) begin
      gnt_valid = in_valid[sel];
      gnt_idx   = sel;
    end
  end

  assign take = rst_n && gnt_valid && load_en;

  // One-hot ready toward the granted channel only.
  always_comb begin
    in_ready = '0;
    if (take) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SW'(N - 1);
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= in_data[32'(gnt_idx)*W +: W];
      out_chan  <= gnt_idx;
      ptr       <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
